// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard stall/flush control for a 5-stage pipe with ID-stage branch compare.
// Optional stall-cycle counter is enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  Rs_id,
    input  logic [4:0]  Rt_id,
    input  logic        UsesRt_id,
    input  logic        Branch_id,
    input  logic        BranchTaken_id,
    input  logic        MemRead_ex,
    input  logic        RegWrite_ex,
    input  logic [4:0]  writeRegOut_ex,
    input  logic        MemRead_mem,
    input  logic [4:0]  writeRegOut_mem,
    input  logic        Freeze,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        Bubble_ex,
    output logic        Flush_if,
    output logic [15:0] StallCount
);

    typedef enum logic {
        IDLE  = 1'b0,
        HOLD1 = 1'b1
    } state_t;

    state_t state;

    logic match_ex;
    logic match_mem;
    logic hazard_h1;
    logic hazard_h2;
    logic stall;

    // Register 0 is hardwired, so a zero destination never creates a dependency.
    always_comb begin
        match_ex  = (writeRegOut_ex != 5'd0) &&
                    ((Rs_id == writeRegOut_ex) || (UsesRt_id && (Rt_id == writeRegOut_ex)));
        match_mem = (writeRegOut_mem != 5'd0) &&
                    ((Rs_id == writeRegOut_mem) || (UsesRt_id && (Rt_id == writeRegOut_mem)));
    end

    always_comb begin
        hazard_h2 = Branch_id && MemRead_ex && match_ex;
        hazard_h1 = (!Branch_id && MemRead_ex && match_ex) ||
                    (Branch_id && RegWrite_ex && !MemRead_ex && match_ex) ||
                    (Branch_id && MemRead_mem && match_mem);
    end

    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = hazard_h1 || hazard_h2;
            HOLD1:   stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // A branch waiting on a load needs a second bubble; HOLD1 supplies it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (!Freeze) begin
            case (state)
                IDLE:    state <= hazard_h2 ? HOLD1 : IDLE;
                HOLD1:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Freeze outranks stall: nothing advances and no bubble is injected.
    always_comb begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        Bubble_ex = 1'b0;
        Flush_if  = 1'b0;
        if (reset_n) begin
            if (Freeze) begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
            end else if (stall) begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                Bubble_ex = 1'b1;
            end else begin
                Flush_if  = Branch_id && BranchTaken_id;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= 16'd0;
        end else if (stall && !Freeze && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign StallCount = stall_cnt;
`else
    assign StallCount = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl; counter checks follow HAZARD_PERF_CNT_EN.
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        reset_n;
    logic [4:0]  Rs_id;
    logic [4:0]  Rt_id;
    logic        UsesRt_id;
    logic        Branch_id;
    logic        BranchTaken_id;
    logic        MemRead_ex;
    logic        RegWrite_ex;
    logic [4:0]  writeRegOut_ex;
    logic        MemRead_mem;
    logic [4:0]  writeRegOut_mem;
    logic        Freeze;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        Bubble_ex;
    logic        Flush_if;
    logic [15:0] StallCount;

    int checks;
    int errors;
    logic [15:0] exp_cnt;

    hazard_stall_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .Rs_id          (Rs_id),
        .Rt_id          (Rt_id),
        .UsesRt_id      (UsesRt_id),
        .Branch_id      (Branch_id),
        .BranchTaken_id (BranchTaken_id),
        .MemRead_ex     (MemRead_ex),
        .RegWrite_ex    (RegWrite_ex),
        .writeRegOut_ex (writeRegOut_ex),
        .MemRead_mem    (MemRead_mem),
        .writeRegOut_mem(writeRegOut_mem),
        .Freeze         (Freeze),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .Bubble_ex      (Bubble_ex),
        .Flush_if       (Flush_if),
        .StallCount     (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                                 input logic br, input logic taken, input logic mr_ex,
                                 input logic rw_ex, input logic [4:0] wr_ex, input logic mr_mem,
                                 input logic [4:0] wr_mem, input logic frz);
        Rs_id           = rs;
        Rt_id           = rt;
        UsesRt_id       = uses_rt;
        Branch_id       = br;
        BranchTaken_id  = taken;
        MemRead_ex      = mr_ex;
        RegWrite_ex     = rw_ex;
        writeRegOut_ex  = wr_ex;
        MemRead_mem     = mr_mem;
        writeRegOut_mem = wr_mem;
        Freeze          = frz;
        #2;
    endtask

    // Expected vector order: {PCWrite, IFIDWrite, Bubble_ex, Flush_if}
    task automatic checkOutput(input string tag, input logic [3:0] expected);
        logic [3:0] observed;
        observed = {PCWrite, IFIDWrite, Bubble_ex, Flush_if};
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s got pc/ifid/bub/flush=%b expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkCount(input string tag, input logic [15:0] expected);
        checks++;
        assert (StallCount === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s got StallCount=%h expected %h", tag, StallCount, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("reset_idle", 4'b1100);
        checkCount("reset_cnt", 16'd0);
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0);
        checkOutput("reset_masks_hazard", 4'b1100);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        stepClock();
        stepClock();
        reset_n = 1'b1;
        stepClock();

        $display("[TB] no hazard");
        checkOutput("no_hazard", 4'b1100);

        $display("[TB] load-use");
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0);
        checkOutput("load_use_stall", 4'b0010);
        stepClock();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("load_use_release", 4'b1100);
        stepClock();

        $display("[TB] branch after load");
        applyStimulus(5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0);
        checkOutput("br_load_cyc1", 4'b0010);
        stepClock();
        applyStimulus(5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("br_load_hold1", 4'b0010);
        stepClock();
        checkOutput("br_load_flush", 4'b1101);
        stepClock();

        $display("[TB] branch after ALU write");
        applyStimulus(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
        checkOutput("br_alu_stall", 4'b0010);
        stepClock();
        applyStimulus(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("br_alu_flush", 4'b1101);
        stepClock();

        $display("[TB] operand filtering");
        applyStimulus(5'd3, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0);
        checkOutput("rt_unused", 4'b1100);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("dest_reg0", 4'b1100);
        stepClock();
        checkOutput("dest_reg0_next", 4'b1100);

        $display("[TB] MEM-stage load");
        applyStimulus(5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
        checkOutput("br_mem_load", 4'b0010);
        applyStimulus(5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
        checkOutput("nobr_mem_load", 4'b1100);
        stepClock();

        $display("[TB] freeze in HOLD1");
        applyStimulus(5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0);
        checkOutput("frz_h2", 4'b0010);
        stepClock();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        checkOutput("frz_hold_a", 4'b0000);
        stepClock();
        checkOutput("frz_hold_b", 4'b0000);
        stepClock();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("frz_state_kept", 4'b0010);
        stepClock();
        checkOutput("frz_back_idle", 4'b1100);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        checkOutput("frz_no_flush", 4'b0000);

        $display("[TB] freeze blocks HOLD1 entry");
        applyStimulus(5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 1'b1);
        checkOutput("frz_h2_idle", 4'b0000);
        stepClock();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("frz_h2_no_hold", 4'b1100);
        stepClock();

        $display("[TB] reset during HOLD1");
        applyStimulus(5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0);
        stepClock();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("rst_pre_hold1", 4'b0010);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_async", 4'b1100);
        checkCount("rst_async_cnt", 16'd0);
        #2;
        reset_n = 1'b1;
        stepClock();
        checkOutput("rst_after_release", 4'b1100);

        $display("[TB] stall counter");
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0);
        stepClock();
        stepClock();
        stepClock();
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b1);
        stepClock();
        stepClock();
`ifdef HAZARD_PERF_CNT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        checkCount("cnt_three", exp_cnt);

`ifdef HAZARD_PERF_CNT_EN
        $display("[TB] counter saturation");
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 70000; i++) begin
            if (StallCount == 16'hFFFF) break;
            stepClock();
        end
        checkCount("cnt_reach_max", 16'hFFFF);
        stepClock();
        stepClock();
        checkCount("cnt_saturated", 16'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 Rs_id, Rt_id  input  5 each  source registers of the instruction in ID.
REQ-005 UsesRt_id  input  1  the ID instruction reads Rt.
REQ-006 Branch_id  input  1  the ID instruction is a branch compared in ID.
REQ-007 BranchTaken_id  input  1  the ID branch compare result is taken.
REQ-008 MemRead_ex, RegWrite_ex  input  1 each  EX-stage load and register-write flags.
REQ-009 writeRegOut_ex  input  5  EX-stage destination register.
REQ-010 MemRead_mem  input  1  MEM-stage load flag.
REQ-011 writeRegOut_mem  input  5  MEM-stage destination register.
REQ-012 Freeze  input  1  external whole-pipe hold, such as memory not ready.
REQ-013 PCWrite  output  1  PC update enable.
REQ-014 IFIDWrite  output  1  IF/ID register update enable.
REQ-015 Bubble_ex  output  1  zero the control fields entering ID/EX.
REQ-016 Flush_if  output  1  squash the IF/ID contents for a taken branch.
REQ-017 StallCount  output  16  count of stall cycles.

Function
REQ-018 Match terms SHALL be defined as follows.
- mEX = writeRegOut_ex != 0 and (Rs_id == writeRegOut_ex, or UsesRt_id and Rt_id == writeRegOut_ex).
- mMEM is the same using writeRegOut_mem.
REQ-019 Hazard classes SHALL be detected combinationally as follows.
- H2: Branch_id & MemRead_ex & mEX.
- H1: any of the following:
  - not Branch_id & MemRead_ex & mEX;
  - Branch_id & RegWrite_ex & not MemRead_ex & mEX;
  - Branch_id & MemRead_mem & mMEM.
REQ-020 The FSM SHALL have two states, IDLE and HOLD1, and SHALL reset to IDLE.
REQ-021 In IDLE, stall = H1 | H2, evaluated in the same cycle with zero latency (Mealy).
REQ-022 From IDLE, the FSM SHALL go to HOLD1 on H2 and not Freeze; otherwise it SHALL stay in IDLE.
REQ-023 In HOLD1, stall = 1 regardless of inputs, and the FSM SHALL return to IDLE on the next non-Freeze edge.
REQ-024 Whenever stall = 1, the outputs SHALL be PCWrite = 0, IFIDWrite = 0, Bubble_ex = 1.
REQ-025 Whenever stall = 0 and Freeze = 0, the outputs SHALL be PCWrite = 1, IFIDWrite = 1, Bubble_ex = 0.
REQ-026 When Freeze = 1, the outputs SHALL be PCWrite = 0, IFIDWrite = 0, Bubble_ex = 0, and the state SHALL hold; Freeze takes priority over stall.
REQ-027 Flush_if SHALL equal Branch_id & BranchTaken_id & not stall & not Freeze.
- Flush_if SHALL never be asserted in a cycle where IFIDWrite = 0.
REQ-028 When H1 and H2 are both true, the block SHALL treat the cycle as H2.
REQ-029 Destination register 0 SHALL never produce a hazard.

Reset
REQ-030 Asserting reset_n low SHALL immediately force the state to IDLE, independent of clk.
REQ-031 While reset_n is low, the outputs SHALL be PCWrite = 1, IFIDWrite = 1, Bubble_ex = 0, Flush_if = 0, StallCount = 0.
REQ-032 Reset asserted during HOLD1 SHALL abandon the pending stall; the first cycle after release SHALL be evaluated from IDLE.

Configuration
REQ-033 When HAZARD_PERF_CNT_EN is defined, StallCount SHALL be a register that increments on each clk edge where stall = 1 and Freeze = 0.
- It SHALL saturate at 16'hFFFF.
- It SHALL clear only on reset.
REQ-034 When HAZARD_PERF_CNT_EN is not defined, StallCount SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-035 The bench SHALL cover a load-use case.
- Stimulus: MemRead_ex = 1, writeRegOut_ex = 8, Rs_id = 8, Branch_id = 0.
- Response: one cycle of PCWrite = 0 and Bubble_ex = 1; with the same inputs removed, the next cycle is PCWrite = 1.
REQ-036 The bench SHALL cover a branch after a load.
- Stimulus: Branch_id = 1, MemRead_ex = 1, writeRegOut_ex = 9, Rt_id = 9, UsesRt_id = 1.
- Response: the stall lasts exactly 2 cycles (IDLE, then HOLD1), even if the EX inputs clear in cycle 2.
REQ-037 The bench SHALL cover a branch after an ALU write.
- Stimulus: Branch_id = 1, RegWrite_ex = 1, MemRead_ex = 0, writeRegOut_ex = 5, Rs_id = 5.
- Response: a 1-cycle stall, then Flush_if = 1 if BranchTaken_id = 1.
REQ-038 The bench SHALL cover destination register 0.
- Stimulus: writeRegOut_ex = 0, Rs_id = 0, MemRead_ex = 1.
- Response: no stall; PCWrite stays 1.
REQ-039 The bench SHALL cover reset during HOLD1.
- Stimulus: assert reset_n = 0 mid-cycle while in HOLD1.
- Response: PCWrite = 1 immediately, without waiting for a clk edge; the state is IDLE after release.
REQ-040 With HAZARD_PERF_CNT_EN defined, the bench SHALL cover Freeze and the stall counter.
- Stimulus: 3 stall cycles, then 2 Freeze cycles.
- Response: StallCount = 3.
- Saturation stimulus: preload the counter to 16'hFFFF, then apply a stall.
- Saturation response: StallCount stays at 16'hFFFF.
